// File: rtl/booth_r4_seq_mult.sv
// Multi-cycle radix-4 Booth multiplier, signed/unsigned per operation, one 2N-bit product per start.
// Optional early termination is compiled in with `define BOOTH_EARLY_TERM_EN.
module booth_r4_seq_mult #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [1:0]     dbg_state
);
    localparam int W  = 2*N + 2;
    localparam int IW = $clog2(N/2 + 1);
    localparam logic [IW-1:0] LAST_SIGNED   = IW'(N/2 - 1);
    localparam logic [IW-1:0] LAST_UNSIGNED = IW'(N/2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  a_sh;
    logic [N+1:0]  m_sh;
    logic          m_prev;
    logic [IW-1:0] idx;
    logic [IW-1:0] last_idx;

    logic [W-1:0]  addend;
    logic [W-1:0]  acc_next;
    logic [2:0]    triplet;
    logic          accept;
    logic          early_hit;

    // Handshake: start is taken on a rising edge whenever state is IDLE or DONE (busy=0);
    // busy stays high until the edge that enters DONE, where done pulses for one cycle
    // and product is loaded; a start during RUN is ignored.
    assign accept    = start && (state != RUN);
    assign dbg_state = state;

    // The multiplier shifts right two bits per digit, so the current triplet is always
    // at the bottom; the multiplicand shifts left to match the digit weight.
    assign triplet = {m_sh[1], m_sh[0], m_prev};

`ifdef BOOTH_EARLY_TERM_EN
    // Remaining multiplier bits (including the borrowed lower bit) all equal: every
    // further digit recodes to zero.
    assign early_hit = (m_sh == {(N+2){m_prev}});
`else
    assign early_hit = 1'b0;
`endif

    always_comb begin
        addend = '0;
        case (triplet)
            3'b001, 3'b010: addend = a_sh;
            3'b011:         addend = {a_sh[W-2:0], 1'b0};
            3'b100:         addend = ~{a_sh[W-2:0], 1'b0} + W'(1);
            3'b101, 3'b110: addend = ~a_sh + W'(1);
            default:        addend = '0;
        endcase
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            a_sh     <= '0;
            m_sh     <= '0;
            m_prev   <= 1'b0;
            idx      <= '0;
            last_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        acc      <= '0;
                        a_sh     <= is_signed ? {{(N+2){a[N-1]}}, a} : {{(N+2){1'b0}}, a};
                        m_sh     <= is_signed ? {{2{b[N-1]}}, b} : {2'b00, b};
                        m_prev   <= 1'b0;
                        idx      <= '0;
                        last_idx <= is_signed ? LAST_SIGNED : LAST_UNSIGNED;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (early_hit) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= acc[2*N-1:0];
                    end else begin
                        acc    <= acc_next;
                        a_sh   <= {a_sh[W-3:0], 2'b00};
                        m_sh   <= {{2{m_sh[N+1]}}, m_sh[N+1:2]};
                        m_prev <= m_sh[1];
                        idx    <= idx + IW'(1);
                        if (idx == last_idx) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            product <= acc_next[2*N-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
